// File: rtl/hazard_pattern_decoder_if.sv
// Lamp-bus observation interface for the hazard pattern decoder.
// The master drives lamp samples; the slave reports mode and error status.
interface hazard_pattern_decoder_if #(
    parameter int ERR_W = 8
);
    logic             sample_valid;
    logic [2:0]       lamps;
    logic [1:0]       mode;
    logic             mode_valid;
    logic             mode_change;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output sample_valid, lamps,
        input  mode, mode_valid, mode_change, err_pulse, err_count
    );

    modport slave (
        input  sample_valid, lamps,
        output mode, mode_valid, mode_change, err_pulse, err_count
    );
endinterface

// File: rtl/hazard_pattern_decoder.sv
// Recovers the hazard-light wind mode from the lamp pattern stream,
// locking after LOCK_COUNT consistent transitions and counting illegal patterns.
module hazard_pattern_decoder #(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    hazard_pattern_decoder_if.slave  bus
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        T_NONE  = 3'd0,
        T_CALM  = 3'd1,
        T_R2L   = 3'd2,
        T_L2R   = 3'd3,
        T_HOLD  = 3'd4,
        T_OTHER = 3'd5
    } tcls_e;

    state_e           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [1:0]       cls_q, cls_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             valid_q, valid_d;
    logic             chg_q, chg_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             legal;
    tcls_e            tcls;
    logic [CW-1:0]    cnt_nx;

    always_comb begin
        legal = 1'b0;
        unique case (bus.lamps)
            3'b100, 3'b010, 3'b001, 3'b101: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
    end

    // Transition class from the stored pattern to the incoming one.
    always_comb begin
        tcls = T_OTHER;
        if (bus.lamps == prev_q) begin
            tcls = T_HOLD;
        end else begin
            case ({prev_q, bus.lamps})
                6'b101_010, 6'b010_101: tcls = T_CALM;
                6'b001_010, 6'b010_100,
                6'b100_001:             tcls = T_R2L;
                6'b100_010, 6'b010_001,
                6'b001_100:             tcls = T_L2R;
                default:                tcls = T_OTHER;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cls_d     = cls_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        valid_d   = valid_q;
        chg_d     = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        cnt_nx    = cnt_q + 1'b1;

        if (bus.sample_valid) begin
            if (!legal) begin
                err_d   = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                mode_d  = 2'b00;
                valid_d = 1'b0;
                state_d = EMPTY;
                prev_d  = 3'b000;
                cls_d   = 2'b00;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        prev_d  = bus.lamps;
                        state_d = TRACK;
                        cls_d   = 2'b00;
                        cnt_d   = '0;
                    end
                    TRACK: begin
                        if (tcls != T_HOLD) begin
                            prev_d = bus.lamps;
                            if (tcls == T_OTHER) begin
                                cnt_d = '0;
                            end else begin
                                if (tcls[1:0] == cls_q) begin
                                    cnt_d = cnt_nx;
                                end else begin
                                    cls_d = tcls[1:0];
                                    cnt_d = CW'(1);
                                end
                                if (cnt_d == LOCK_N) begin
                                    state_d = LOCKED;
                                    mode_d  = tcls[1:0];
                                    valid_d = 1'b1;
                                    chg_d   = 1'b1;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (tcls != T_HOLD) begin
                            prev_d = bus.lamps;
                            if (tcls[1:0] != cls_q || tcls == T_OTHER) begin
                                // Lock is lost in the same cycle as the
                                // breaking transition.
                                mode_d  = 2'b00;
                                valid_d = 1'b0;
                                state_d = TRACK;
                                if (tcls == T_OTHER) begin
                                    cnt_d = '0;
                                end else begin
                                    cls_d = tcls[1:0];
                                    cnt_d = CW'(1);
                                end
                            end
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            prev_q    <= 3'b000;
            cls_q     <= 2'b00;
            cnt_q     <= '0;
            mode_q    <= 2'b00;
            valid_q   <= 1'b0;
            chg_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            valid_q   <= valid_d;
            chg_q     <= chg_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.mode        = mode_q;
    assign bus.mode_valid  = valid_q;
    assign bus.mode_change = chg_q;
    assign bus.err_pulse   = err_q;
    assign bus.err_count   = err_cnt_q;
endmodule

// File: tb/tb_hazard_pattern_decoder.sv
// Self-checking bench for hazard_pattern_decoder: directed vector table,
// async reset, saturation, and randomized run against a run-length model.
module tb_hazard_pattern_decoder;
    localparam int LC = 3;
    localparam int EW = 8;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    hazard_pattern_decoder_if #(.ERR_W(EW)) bus ();

    hazard_pattern_decoder #(.LOCK_COUNT(LC), .ERR_W(EW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] l;
        logic [1:0] mode;
        logic       mv;
        logic       mc;
        logic       ep;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic v, input logic [2:0] l);
        @(negedge clk);
        bus.sample_valid = v;
        bus.lamps        = l;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.sample_valid = 1'b0;
        bus.lamps        = 3'b000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int outs();
        return {bus.mode, bus.mode_valid, bus.mode_change, bus.err_pulse};
    endfunction

    // Reference model: 1 CALM, 2 R2L, 3 L2R, 4 HOLD, 5 OTHER.
    function automatic int pos(logic [2:0] p);
        case (p)
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int classify(logic [2:0] a, logic [2:0] b);
        int d;
        if (a == b) return 4;
        if ((a == 3'b101 && b == 3'b010) || (a == 3'b010 && b == 3'b101))
            return 1;
        if (pos(a) < 0 || pos(b) < 0) return 5;
        d = (pos(b) - pos(a) + 3) % 3;
        return (d == 1) ? 3 : 2;
    endfunction

    bit         m_have;
    logic [2:0] m_prev;
    int         m_run;
    int         m_last;
    int         m_err;
    int         m_mode;
    bit         m_mv;
    bit         m_mc;
    bit         m_ep;

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_run = 0; m_last = 0;
        m_err = 0; m_mode = 0; m_mv = 0; m_mc = 0; m_ep = 0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] l);
        int  c;
        bit  was;
        m_mc = 0;
        m_ep = 0;
        if (!v) return;
        if (pos(l) < 0 && l != 3'b101) begin
            m_ep = 1;
            if (m_err < (1 << EW) - 1) m_err++;
            m_have = 0; m_run = 0; m_last = 0; m_mv = 0; m_mode = 0;
            return;
        end
        if (!m_have) begin
            m_have = 1; m_prev = l; m_run = 0; m_last = 0;
            return;
        end
        c = classify(m_prev, l);
        if (c == 4) return;
        m_prev = l;
        if (c == 5) begin
            m_run = 0; m_last = 0;
        end else if (c == m_last) begin
            m_run++;
        end else begin
            m_last = c; m_run = 1;
        end
        was  = m_mv;
        m_mv = (m_run >= LC);
        m_mc = m_mv && !was;
        m_mode = m_mv ? m_last : 0;
    endtask

    function automatic logic [2:0] gen(input int kind, input int idx);
        logic [2:0] calm[2];
        logic [2:0] rot[3];
        calm[0] = 3'b101; calm[1] = 3'b010;
        rot[0]  = 3'b100; rot[1]  = 3'b010; rot[2] = 3'b001;
        case (kind)
            0:       return calm[idx % 2];
            1:       return rot[(300 - idx) % 3];
            2:       return rot[idx % 3];
            default: return 3'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        bus.sample_valid = 1'b0;
        bus.lamps        = 3'b000;

        tbl[0]  = '{1, 3'b101, 0, 0, 0, 0};
        tbl[1]  = '{1, 3'b010, 0, 0, 0, 0};
        tbl[2]  = '{1, 3'b101, 0, 0, 0, 0};
        tbl[3]  = '{1, 3'b010, 1, 1, 1, 0};
        tbl[4]  = '{1, 3'b101, 1, 1, 0, 0};
        tbl[5]  = '{1, 3'b111, 0, 0, 0, 1};
        tbl[6]  = '{1, 3'b101, 0, 0, 0, 0};
        tbl[7]  = '{0, 3'b010, 0, 0, 0, 0};
        tbl[8]  = '{1, 3'b010, 0, 0, 0, 0};
        tbl[9]  = '{1, 3'b010, 0, 0, 0, 0};
        tbl[10] = '{0, 3'b101, 0, 0, 0, 0};
        tbl[11] = '{1, 3'b101, 0, 0, 0, 0};
        tbl[12] = '{1, 3'b010, 1, 1, 1, 0};
        tbl[13] = '{1, 3'b001, 0, 0, 0, 0};
        tbl[14] = '{1, 3'b010, 0, 0, 0, 0};
        tbl[15] = '{1, 3'b100, 0, 0, 0, 0};
        tbl[16] = '{1, 3'b001, 2, 1, 1, 0};
        tbl[17] = '{1, 3'b100, 0, 0, 0, 0};
        tbl[18] = '{1, 3'b010, 0, 0, 0, 0};
        tbl[19] = '{1, 3'b001, 3, 1, 1, 0};
        tbl[20] = '{1, 3'b100, 3, 1, 0, 0};
        tbl[21] = '{1, 3'b101, 0, 0, 0, 0};
        tbl[22] = '{1, 3'b010, 0, 0, 0, 0};

        do_reset();
        #1;
        check("reset_outs", outs(), 0);
        check("reset_errcnt", int'(bus.err_count), 0);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].v, tbl[i].l);
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].mode, tbl[i].mv, tbl[i].mc, tbl[i].ep});
        end
        check("tbl_errcnt", int'(bus.err_count), 1);

        // Pulses drop on an idle cycle after a lock.
        step(1, 3'b101);
        step(1, 3'b010);
        step(0, 3'b010);
        check("idle_pulse_drop", outs(), {2'd1, 1'b1, 1'b0, 1'b0});

        // Async reset between edges while locked.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", outs(), 0);
        check("async_rst_err", int'(bus.err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) step(1, 3'b000);
        check("err_sat", int'(bus.err_count), 255);
        check("err_sat_pulse", int'(bus.err_pulse), 1);
        step(0, 3'b000);
        check("err_pulse_drop", int'(bus.err_pulse), 0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        begin
            int kind;
            int idx;
            int bad;
            logic       v;
            logic [2:0] l;
            kind = 0;
            idx  = 0;
            bad  = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c % 12 == 0) kind = $urandom_range(0, 3);
                v = ($urandom_range(0, 9) < 8);
                if ($urandom_range(0, 49) == 0) l = 3'b111;
                else l = gen(kind, idx);
                if (v) idx++;
                step(v, l);
                model_step(v, l);
                n_total++;
                if (outs() == {m_mode[1:0], m_mv, m_mc, m_ep} &&
                    int'(bus.err_count) == m_err) begin
                    n_pass++;
                end else if (bad < 10) begin
                    bad++;
                    $display("FAIL rand%0d: got %0h/%0d expected %0h/%0d",
                             c, outs(), bus.err_count,
                             {m_mode[1:0], m_mv, m_mc, m_ep}, m_err);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
